// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared envelope state encodings and PCM constants
package synth_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

   localparam logic [15:0] PCM_MID   = 16'h8000;
   localparam logic [15:0] LEVEL_MAX = 16'hFFFF;

endpackage

// File: rtl/vca_scale.sv
// rtl/vca_scale.sv - two-stage signed multiply of offset-binary PCM by envelope level
module vca_scale
   import synth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pcm_in,
   input  logic [15:0] level,
   output logic [15:0] pcm_out
);

   logic signed [15:0] sample;
   logic signed [31:0] sample_ext;
   logic signed [31:0] level_ext;
   logic signed [31:0] prod;

   // |sample * level| < 2^31, so 32 signed bits hold the full product
   assign sample     = $signed(pcm_in - PCM_MID);
   assign sample_ext = {{16{sample[15]}}, sample};
   assign level_ext  = $signed({16'b0, level});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod    <= '0;
         pcm_out <= PCM_MID;
      end else begin
         prod    <= sample_ext * level_ext;
         pcm_out <= PCM_MID + prod[31:16];
      end
   end

endmodule

// File: rtl/envelope_vca.sv
// rtl/envelope_vca.sv - per-voice linear ADSR envelope driving an amplitude stage
module envelope_vca
   import synth_pkg::*;
#(
   parameter int TICK_BITS = 10,
   parameter int LEVEL_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               gate,
   input  logic [LEVEL_W-1:0] attack_rate,
   input  logic [LEVEL_W-1:0] decay_rate,
   input  logic [LEVEL_W-1:0] sustain_level,
   input  logic [LEVEL_W-1:0] release_rate,
   input  logic [15:0]        pcm_in,
   output logic [15:0]        pcm_out,
   output logic [LEVEL_W-1:0] env_level,
   output logic [2:0]         env_state,
   output logic               active
);

   logic [TICK_BITS-1:0] tick_cnt;
   logic                 tick;
   logic                 gate_q;
   logic                 rise;
   logic                 fall;
   env_state_t           state;
   env_state_t           state_n;
   logic [LEVEL_W-1:0]   level;
   logic [LEVEL_W-1:0]   level_n;
   logic [LEVEL_W:0]     att_sum;
   logic [LEVEL_W:0]     dec_thr;

   assign tick    = &tick_cnt;
   assign rise    = gate & ~gate_q;
   assign fall    = ~gate & gate_q;
   assign att_sum = {1'b0, level} + {1'b0, attack_rate};
   assign dec_thr = {1'b0, sustain_level} + {1'b0, decay_rate};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         gate_q   <= 1'b0;
         state    <= IDLE;
         level    <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
         gate_q   <= gate;
         state    <= state_n;
         level    <= level_n;
      end
   end

   // Edges win over a coincident tick; a retrigger keeps the current level
   always_comb begin
      state_n = state;
      level_n = level;
      if (rise) begin
         state_n = ATTACK;
      end else if (fall) begin
         if (state == ATTACK || state == DECAY || state == SUSTAIN)
            state_n = RELEASE;
      end else if (tick) begin
         case (state)
            ATTACK: begin
               if (att_sum >= {1'b0, LEVEL_MAX}) begin
                  level_n = LEVEL_MAX;
                  state_n = DECAY;
               end else begin
                  level_n = att_sum[LEVEL_W-1:0];
               end
            end
            DECAY: begin
               if ({1'b0, level} <= dec_thr) begin
                  level_n = sustain_level;
                  state_n = SUSTAIN;
               end else begin
                  level_n = level - decay_rate;
               end
            end
            SUSTAIN: level_n = sustain_level;
            RELEASE: begin
               if (level <= release_rate) begin
                  level_n = '0;
                  state_n = IDLE;
               end else begin
                  level_n = level - release_rate;
               end
            end
            default: level_n = '0;
         endcase
      end
   end

   always_comb begin
      env_state = state;
      env_level = level;
      active    = (state != IDLE);
   end

   vca_scale u_scale (
      .clk     (clk),
      .rst_n   (rst_n),
      .pcm_in  (pcm_in),
      .level   (level),
      .pcm_out (pcm_out)
   );

endmodule

// File: tb/tb_envelope_vca.sv
// tb/tb_envelope_vca.sv - scoreboard bench for envelope_vca against an integer ADSR model
module tb_envelope_vca;

   typedef struct packed {
      logic [15:0] lvl;
      logic [2:0]  st;
   } env_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        gate;
   logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
   logic [15:0] pcm_in;
   logic [15:0] pcm_out;
   logic [15:0] env_level;
   logic [2:0]  env_state;
   logic        active;

   int checks = 0;
   int errors = 0;
   bit run = 0;

   env_t        env_q[$];
   logic [15:0] pcm_q[$];

   int m_level, m_state, m_cnt;
   bit m_gate_q;

   envelope_vca #(.TICK_BITS(2), .LEVEL_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gate          (gate),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .pcm_in        (pcm_in),
      .pcm_out       (pcm_out),
      .env_level     (env_level),
      .env_state     (env_state),
      .active        (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected PCM uses the level the model holds in the cycle pcm_in is applied
   task automatic step();
      int nl, ns, s;
      bit rise, fall, tick;
      longint p, e;
      s = int'(pcm_in) - 32768;
      p = longint'(s) * longint'(m_level);
      e = 32768 + (p >>> 16);
      pcm_q.push_back(e[15:0]);
      rise = gate && !m_gate_q;
      fall = !gate && m_gate_q;
      tick = (m_cnt == 3);
      nl = m_level;
      ns = m_state;
      if (rise) ns = 1;
      else if (fall) begin
         if (m_state >= 1 && m_state <= 3) ns = 4;
      end else if (tick) begin
         case (m_state)
            1: if (m_level + int'(attack_rate) >= 65535) begin nl = 65535; ns = 2; end
               else nl = m_level + int'(attack_rate);
            2: if (m_level <= int'(sustain_level) + int'(decay_rate)) begin nl = int'(sustain_level); ns = 3; end
               else nl = m_level - int'(decay_rate);
            3: nl = int'(sustain_level);
            4: if (m_level <= int'(release_rate)) begin nl = 0; ns = 0; end
               else nl = m_level - int'(release_rate);
            default: nl = 0;
         endcase
      end
      env_q.push_back({nl[15:0], ns[2:0]});
      m_cnt = (m_cnt + 1) % 4;
      m_gate_q = gate;
      @(posedge clk);
      m_level = nl;
      m_state = ns;
      @(negedge clk);
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      for (int i = 0; i < 64 && seen < n; i++) begin
         bit t;
         t = (m_cnt == 3);
         pcm_in = 16'($urandom);
         step();
         if (t) seen++;
      end
      chk("tick_budget", seen, n);
   endtask

   task automatic randomize_inputs(input bit hold_gate);
      gate          = hold_gate ? 1'b1 : 1'($urandom);
      attack_rate   = 16'($urandom);
      decay_rate    = 16'($urandom);
      sustain_level = 16'($urandom);
      release_rate  = 16'($urandom);
      pcm_in        = 16'($urandom);
   endtask

   task automatic do_reset(input bit hold_gate);
      run = 0;
      rst_n = 1'b0;
      env_q.delete();
      pcm_q.delete();
      repeat (3) begin
         @(negedge clk);
         randomize_inputs(hold_gate);
      end
      chk("rst_pcm_out", pcm_out, 16'h8000);
      chk("rst_env_level", env_level, 16'h0000);
      chk("rst_env_state", env_state, 3'd0);
      chk("rst_active", active, 1'b0);
      m_level = 0; m_state = 0; m_cnt = 0; m_gate_q = 0;
      rst_n = 1'b1;
      run = 1;
   endtask

   always @(posedge clk) begin
      env_t e;
      logic [15:0] x;
      #1;
      if (run && rst_n) begin
         if (env_q.size() > 0) begin
            e = env_q.pop_front();
            chk("sb_env_level", env_level, e.lvl);
            chk("sb_env_state", env_state, e.st);
            chk("sb_active", active, e.st != 3'd0);
         end
         if (pcm_q.size() >= 2) begin
            x = pcm_q.pop_front();
            chk("sb_pcm_out", pcm_out, x);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_lvl;
      rst_n = 1'b0;
      randomize_inputs(1'b0);
      do_reset(1'b0);

      // attack, decay, sustain tracking, release, retrigger
      gate = 0; attack_rate = 16'h4000; decay_rate = 16'h1000;
      sustain_level = 16'hC000; release_rate = 16'h8000;
      step();
      gate = 1;
      step();
      chk("rise_state", env_state, 3'd1);
      chk("rise_level", env_level, 16'h0000);
      wait_ticks(1); chk("att1", env_level, 16'h4000);
      wait_ticks(1); chk("att2", env_level, 16'h8000);
      wait_ticks(1); chk("att3", env_level, 16'hC000); chk("att3_state", env_state, 3'd1);
      wait_ticks(1); chk("att4", env_level, 16'hFFFF); chk("att4_state", env_state, 3'd2);
      wait_ticks(1); chk("dec1", env_level, 16'hEFFF);
      wait_ticks(1); chk("dec2", env_level, 16'hDFFF);
      wait_ticks(1); chk("dec3", env_level, 16'hCFFF); chk("dec3_state", env_state, 3'd2);
      wait_ticks(1); chk("dec4", env_level, 16'hC000); chk("sus_state", env_state, 3'd3);
      sustain_level = 16'hA000;
      wait_ticks(1); chk("sus_track", env_level, 16'hA000);
      sustain_level = 16'hC000;
      wait_ticks(1); chk("sus_back", env_level, 16'hC000);
      gate = 0;
      step();
      chk("rel_state", env_state, 3'd4); chk("rel_hold", env_level, 16'hC000);
      wait_ticks(1); chk("rel1", env_level, 16'h4000);
      attack_rate = 16'h1000; gate = 1;
      step();
      chk("retrig_state", env_state, 3'd1); chk("retrig_level", env_level, 16'h4000);
      wait_ticks(1); chk("retrig_att", env_level, 16'h5000);
      gate = 0;
      step();
      wait_ticks(1);
      chk("rel_idle_level", env_level, 16'h0000);
      chk("rel_idle_state", env_state, 3'd0);
      chk("rel_idle_active", active, 1'b0);

      // rising edge in the same cycle as a tick during RELEASE
      attack_rate = 16'h2000; gate = 1;
      step();
      wait_ticks(2);
      gate = 0; release_rate = 16'h1000;
      step();
      for (int i = 0; i < 8 && m_cnt != 3; i++) step();
      chk("coinc_is_tick", m_cnt, 3);
      exp_lvl = m_level;
      gate = 1;
      step();
      chk("coinc_state", env_state, 3'd1);
      chk("coinc_level", env_level, exp_lvl[15:0]);

      // asynchronous reset mid-ATTACK, then gate held high through release
      pcm_in = 16'h1234;
      wait_ticks(1);
      #2;
      run = 0;
      rst_n = 1'b0;
      #1;
      chk("async_pcm_out", pcm_out, 16'h8000);
      chk("async_env_level", env_level, 16'h0000);
      chk("async_env_state", env_state, 3'd0);
      chk("async_active", active, 1'b0);
      do_reset(1'b1);
      attack_rate = 16'h8000;
      step();
      chk("gate_hold_attack", env_state, 3'd1);

      // scaling at level 0x8000, frozen by a zero attack rate
      wait_ticks(1);
      chk("scale_level", env_level, 16'h8000);
      attack_rate = 16'h0000;
      pcm_in = 16'hFFFF; step(); step(); chk("scale_ffff", pcm_out, 16'hBFFF);
      pcm_in = 16'h0000; step(); step(); chk("scale_0000", pcm_out, 16'h4000);
      pcm_in = 16'h8000; step(); step(); chk("scale_8000", pcm_out, 16'h8000);
      wait_ticks(2);
      chk("zero_rate_freeze", env_level, 16'h8000);

      // randomized traffic with one reset in the middle
      for (int i = 0; i < 1600; i++) begin
         if (i == 800) do_reset(1'b0);
         if ($urandom_range(0, 11) == 0) gate = ~gate;
         if ($urandom_range(0, 40) == 0) begin
            attack_rate   = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            decay_rate    = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'h3FFF));
            release_rate  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'h3FFF));
         end
         if ($urandom_range(0, 30) == 0) sustain_level = 16'($urandom);
         pcm_in = 16'($urandom);
         step();
      end
      step();
      step();
      run = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
